// File: rtl/gf2m_poly_reducer.sv
// Word-serial reduction of a GF(2)[x] product modulo P(x) = x^M + POLY_LOW(x).
// Each REDUCE cycle clears one STEP-wide window of high coefficients, walking from the top down.
module gf2m_poly_reducer #(
   parameter int            IN_W     = 384,
   parameter int            M        = 163,
   parameter logic [M-1:0]  POLY_LOW = 163'hC9,
   parameter int            STEP     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [M-1:0]    out_data,
   output logic            busy
);

   function automatic int poly_deg(input logic [M-1:0] p);
      int d;
      d = 0;
      for (int i = 0; i < M; i++)
         if (p[i]) d = i;
      return d;
   endfunction

   localparam int N     = (IN_W - M + STEP - 1) / STEP;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int SH_W  = $clog2(IN_W);
   localparam int D     = poly_deg(POLY_LOW);

   // Folds must land strictly below the window being cleared.
   if (STEP < 1 || STEP > M - D - 1) begin : g_step_check
      $error("gf2m_poly_reducer: STEP out of range for POLY_LOW degree");
   end

   // Carry-less product of the window bits with POLY_LOW, aligned to bit 0.
   function automatic logic [IN_W-1:0] fold_window(input logic [STEP-1:0] win);
      logic [IN_W-1:0] f;
      f = '0;
      for (int i = 0; i < STEP; i++)
         if (win[i]) f = f ^ (IN_W'(POLY_LOW) << i);
      return f;
   endfunction

   typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

   state_t          state;
   logic [CNT_W-1:0] cnt;
   logic [IN_W-1:0] acc;

   logic [SH_W-1:0] lo;
   logic [STEP-1:0] win_mask;
   logic [STEP-1:0] win;
   logic [IN_W-1:0] clr;
   logic [IN_W-1:0] fold;
   logic [IN_W-1:0] acc_next;

   always_comb begin
      int lo_i;
      int wid;
      lo_i = IN_W - (int'(cnt) + 1) * STEP;
      if (lo_i < M) lo_i = M;
      wid = IN_W - int'(cnt) * STEP - lo_i;
      lo = SH_W'(lo_i);
      win_mask = '0;
      for (int i = 0; i < STEP; i++)
         win_mask[i] = (i < wid);
      win = STEP'(acc >> lo) & win_mask;
      clr = IN_W'(win_mask) << lo;
      fold = fold_window(win);
      acc_next = (acc & ~clr) ^ (fold << (lo - SH_W'(M)));
   end

   // ---- control / accumulator register stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= in_data;
                  cnt      <= '0;
                  state    <= REDUCE;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            REDUCE: begin
               acc <= acc_next;
               if (cnt == CNT_W'(N - 1)) begin
                  state     <= DONE;
                  out_data  <= acc_next[M-1:0];
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf2m_poly_reducer.sv
// Randomized bench for gf2m_poly_reducer against polynomial long-division and
// shift-and-add field-multiply reference models.
module tb_gf2m_poly_reducer;

   localparam int IN_W = 384;
   localparam int M    = 163;
   localparam int STEP = 32;
   localparam int N    = 7;
   localparam logic [M-1:0]    POLY_LOW = 163'hC9;
   localparam logic [IN_W-1:0] P_FULL   = (IN_W'(1) << M) | IN_W'(POLY_LOW);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [IN_W-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [M-1:0]    out_data;
   logic            busy;

   int n_tests = 0;
   int n_fail  = 0;

   gf2m_poly_reducer #(.IN_W(IN_W), .M(M), .POLY_LOW(POLY_LOW), .STEP(STEP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Long division by P(x), highest coefficient first.
   function automatic logic [M-1:0] ref_mod(input logic [IN_W-1:0] v);
      logic [IN_W-1:0] t;
      t = v;
      for (int p = IN_W - 1; p >= M; p--)
         if (t[p]) t = t ^ (P_FULL << (p - M));
      return t[M-1:0];
   endfunction

   function automatic logic [IN_W-1:0] clmul(input logic [191:0] a, input logic [191:0] b);
      logic [IN_W-1:0] r;
      r = '0;
      for (int i = 0; i < 192; i++)
         if (b[i]) r = r ^ (IN_W'(a) << i);
      return r;
   endfunction

   // Field multiply with reduction interleaved at every shift.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] r;
      logic         c;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         c = r[M-1];
         r = r << 1;
         if (c) r = r ^ POLY_LOW;
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   function automatic logic [IN_W-1:0] rand_wide();
      logic [IN_W-1:0] v;
      for (int w = 0; w < IN_W / 32; w++)
         v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic run_op(input logic [IN_W-1:0] d, output logic [M-1:0] res, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_data;
   endtask

   task automatic op_check(input string tag, input logic [IN_W-1:0] v, input logic [M-1:0] exp);
      logic [M-1:0] res;
      int           lat;
      out_ready = 1'b1;
      run_op(v, res, lat);
      check({tag, "_data"}, IN_W'(res), IN_W'(exp));
      check({tag, "_lat"}, IN_W'(lat), IN_W'(N));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [M-1:0]    res;
      logic [M-1:0]    e;
      logic [M-1:0]    a;
      logic [M-1:0]    b;
      logic [IN_W-1:0] v;
      logic [191:0]    tmp;
      int              lat;
      logic            seen;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", IN_W'(in_ready), IN_W'(1));
      check("rst_out_valid", IN_W'(out_valid), IN_W'(0));
      check("rst_out_data", IN_W'(out_data), IN_W'(0));
      check("rst_busy", IN_W'(busy), IN_W'(0));

      // Pass-through with a one-cycle output pulse
      out_ready = 1'b1;
      e = {3'h5, {20{8'hA5}}};
      run_op(IN_W'(e), res, lat);
      check("pt_data", IN_W'(res), IN_W'(e));
      check("pt_lat", IN_W'(lat), IN_W'(N));
      @(posedge clk); #1;
      check("pt_pulse_end", IN_W'(out_valid), IN_W'(0));
      check("pt_in_ready", IN_W'(in_ready), IN_W'(1));

      op_check("x163", IN_W'(1) << 163, 163'hC9);
      e = '0; e[44] = 1'b1; e[43] = 1'b1; e[40] = 1'b1; e[37] = 1'b1;
      op_check("x200", IN_W'(1) << 200, e);
      e = '0; e[162] = 1'b1; e[13] = 1'b1; e[11] = 1'b1; e[6] = 1'b1; e[2] = 1'b1;
      op_check("x325", IN_W'(1) << 325, e);
      op_check("x383", IN_W'(1) << 383, ref_mod(IN_W'(1) << 383));
      op_check("zero", '0, '0);
      op_check("ones", '1, ref_mod('1));

      // Backpressure: result held, new operands ignored
      out_ready = 1'b0;
      v = rand_wide();
      run_op(v, res, lat);
      check("bp_data", IN_W'(res), IN_W'(ref_mod(v)));
      check("bp_lat", IN_W'(lat), IN_W'(N));
      for (int c = 0; c < 20; c++) begin
         in_valid = (c % 2 == 0);
         in_data  = rand_wide();
         @(posedge clk); #1;
         check("bp_hold_data", IN_W'(out_data), IN_W'(ref_mod(v)));
         check("bp_hold_valid", IN_W'(out_valid), IN_W'(1));
         check("bp_hold_in_ready", IN_W'(in_ready), IN_W'(0));
      end
      in_valid = 1'b0;
      in_data  = '0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", IN_W'(out_valid), IN_W'(0));
      check("bp_release_in_ready", IN_W'(in_ready), IN_W'(1));
      v = rand_wide();
      op_check("bp_next", v, ref_mod(v));

      // Reset while cnt == 3 discards the operand
      v = rand_wide();
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_busy", IN_W'(busy), IN_W'(1));
      check("mid_in_ready", IN_W'(in_ready), IN_W'(0));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_out_valid", IN_W'(out_valid), IN_W'(0));
      check("mid_rst_out_data", IN_W'(out_data), IN_W'(0));
      check("mid_rst_in_ready", IN_W'(in_ready), IN_W'(1));
      check("mid_rst_busy", IN_W'(busy), IN_W'(0));
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_output", IN_W'(seen), IN_W'(0));
      v = rand_wide();
      op_check("mid_recover", v, ref_mod(v));

      // Random sweep, with some inputs narrowed to exercise short operands
      for (int i = 0; i < 1000; i++) begin
         v = rand_wide();
         if (i % 4 == 1) v = v >> $urandom_range(0, IN_W - 1);
         if (i % 50 == 7) v = '1;
         op_check("rand", v, ref_mod(v));
      end

      // Multiplier chain with zero-padded 163-bit operands
      for (int i = 0; i < 100; i++) begin
         for (int w = 0; w < 6; w++) tmp[w*32 +: 32] = $urandom;
         a = tmp[M-1:0];
         for (int w = 0; w < 6; w++) tmp[w*32 +: 32] = $urandom;
         b = tmp[M-1:0];
         op_check("chain", clmul(192'(a), 192'(b)), gf_mul(a, b));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gf2m_poly_reducer.md
Name: gf2m_poly_reducer

Overview:
- Downstream stage of the 192x192 carry-less (GF(2)[x]) Toom-Cook multiplier.
- Takes its 384-bit unreduced polynomial product and reduces it modulo a fixed irreducible polynomial P(x) = x^M + POLY_LOW(x). Produces the M-bit GF(2^M) field element.
- Word-serial: clears STEP high-order coefficients per cycle.
- Uses a valid/ready handshake on both sides so it can sit between the multiplier capture register and the field-arithmetic datapath.

Parameters:
- IN_W, 384, width of the unreduced product input (bit i = coefficient of x^i).
- M, 163, field degree; output width.
- POLY_LOW, 163'hC9, low part of P(x) (x^7+x^6+x^3+1 for NIST B-163); degree D = 7 for the default.
- STEP, 32, coefficients folded per REDUCE cycle. Elaboration-time constraint: 1 <= STEP <= M-D-1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block can accept an operand.
- in_data, input, IN_W, unreduced product.
- out_valid, output, 1, out_data holds a reduced result.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, M, in_data mod P(x).
- busy, output, 1, high in REDUCE state.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, accumulator acc = 0, cnt = 0.
  - out_valid = 0, out_data = 0, busy = 0.
  - rst dominates everything, including mid-REDUCE or in DONE; any in-flight operand is discarded with no output.
- Constants:
  - N = ceil((IN_W-M)/STEP); N = 7 for the defaults.
  - Window j (j = 0..N-1) covers bit positions hi_j = IN_W-1-j*STEP down to lo_j = max(M, IN_W-(j+1)*STEP).
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: acc <= in_data, cnt <= 0, state <= REDUCE.
- REDUCE:
  - in_ready = 0, busy = 1.
  - Each edge: for every set bit p in window cnt, clear acc[p] and XOR POLY_LOW << (p-M) into acc. All folds in a window are computed combinationally from the pre-edge acc; the STEP constraint guarantees folded terms land strictly below lo_cnt.
  - If cnt == N-1: state <= DONE, out_data <= acc_next[M-1:0], out_valid <= 1. Otherwise cnt <= cnt+1.
- DONE:
  - in_ready = 0; out_valid = 1; out_data stable until accepted.
  - On an edge with out_ready = 1: out_valid <= 0, state <= IDLE.
  - out_ready = 0 holds the result indefinitely.
- Latency and throughput:
  - Accept edge k; out_valid is high after edge k+N (N REDUCE edges follow the accept edge). With defaults, out_valid rises 7 edges after accept.
  - Throughput is one result per N+2 cycles with out_ready tied high.
  - No overlap: a new operand is accepted only in IDLE.
- Arithmetic:
  - Pure GF(2) arithmetic, XOR only, no carries.
  - Bits of in_data at positions >= M, including IN_W-1, are fully reduced.
  - Input already < 2^M passes through unchanged.
  - in_data = 0 gives out_data = 0.
- Inputs are ignored:
  - in_valid while not IDLE.
  - out_ready while not DONE.

Test Plan:
- Reset mid-REDUCE: assert rst for 1 cycle at cnt = 3 -> next cycle state IDLE, out_valid 0, out_data 0, in_ready 1; no result emitted.
- Pass-through, defaults, out_ready = 1: in_data = 163'h5A5A...A5 (< 2^163) accepted -> out_data identical, out_valid high exactly 7 edges after accept, one cycle long.
- Single high coefficients:
  - in_data = 1<<163 -> out_data = 163'hC9.
  - in_data = 1<<200 -> out_data = bits {44,43,40,37} set.
- Double fold: in_data = 1<<325 -> out_data = x^162+x^13+x^11+x^6+x^2 (bits 162, 13, 11, 6, 2). Covers a fold landing >= M and being re-reduced in a later window.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid -> out_data stable, in_ready stays 0, in_valid pulses ignored.
  - Then out_ready = 1 -> IDLE next cycle, next operand accepted.
- Random sweep against a software model: 1000 random 384-bit values, including all-ones (bit 383 set) -> out_data == in_data mod (x^163+x^7+x^6+x^3+1). Also chain with the multiplier model using random 163-bit operands zero-padded to 192 bits.
